// File: rtl/ysyx_axi_rr_arbiter.sv
// NM-client single-beat request arbiter onto one AXI4 master port, one transaction in flight.
// Define YSYX_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default build is round-robin.
module ysyx_axi_rr_arbiter #(
    parameter int NM      = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BUS_W   = 64,
    parameter int ID_BASE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NM-1:0]          req_valid,
    output logic [NM-1:0]          req_ready_o,
    input  logic [NM-1:0]          req_write,
    input  logic [NM*ADDR_W-1:0]   req_addr,
    input  logic [NM*3-1:0]        req_size,
    input  logic [NM*DATA_W-1:0]   req_wdata,
    input  logic [NM*DATA_W/8-1:0] req_wstrb,
    output logic [NM-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]      rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic [ADDR_W-1:0]      axi_araddr,
    output logic                   axi_arvalid,
    output logic [3:0]             axi_arid,
    output logic [2:0]             axi_arsize,
    output logic [7:0]             axi_arlen,
    output logic [1:0]             axi_arburst,
    input  logic                   axi_arready,
    input  logic                   axi_rvalid,
    input  logic [BUS_W-1:0]       axi_rdata,
    input  logic [1:0]             axi_rresp,
    input  logic                   axi_rlast,
    input  logic [3:0]             axi_rid,
    output logic                   axi_rready,
    output logic [ADDR_W-1:0]      axi_awaddr,
    output logic                   axi_awvalid,
    output logic [3:0]             axi_awid,
    output logic [2:0]             axi_awsize,
    output logic [7:0]             axi_awlen,
    output logic [1:0]             axi_awburst,
    input  logic                   axi_awready,
    output logic                   axi_wvalid,
    output logic [BUS_W-1:0]       axi_wdata,
    output logic [BUS_W/8-1:0]     axi_wstrb,
    output logic                   axi_wlast,
    input  logic                   axi_wready,
    input  logic                   axi_bvalid,
    input  logic [1:0]             axi_bresp,
    input  logic [3:0]             axi_bid,
    output logic                   axi_bready
);

    localparam int GW   = (NM > 1) ? $clog2(NM) : 1;
    localparam int DB   = DATA_W / 8;
    localparam int BB   = BUS_W / 8;
    localparam int L    = BUS_W / DATA_W;
    localparam int LO_W = $clog2(DB);
    localparam int OFF_W = $clog2(BB);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_B    = 3'd4;

    logic [2:0]        state;
    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     lat_g;
    logic [ADDR_W-1:0] lat_addr;
    logic [2:0]        lat_size;
    logic [DATA_W-1:0] lat_wdata;
    logic [DB-1:0]     lat_wstrb;
    logic              aw_done;
    logic              w_done;

    logic [GW-1:0]     grant_idx;
    logic [GW-1:0]     scan;
    logic              grant_any;
    logic [3:0]        cur_id;
    logic [OFF_W-1:0]  lane;
    logic [LO_W-1:0]   addr_lo;
    logic [DATA_W-1:0] wd_sh;
    logic [DB-1:0]     ws_sh;
    logic [DATA_W-1:0] rd_slice;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = last_grant;
`ifdef YSYX_ARB_FIXED_PRIO_EN
        for (int i = NM - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_idx = GW'(i);
                grant_any = 1'b1;
            end
        end
`else
        // Scan starts one past the previous winner so every client wins within NM grants.
        for (int k = 1; k <= NM; k++) begin
            scan = GW'((int'(last_grant) + k) % NM);
            if (!grant_any && req_valid[scan]) begin
                grant_idx = scan;
                grant_any = 1'b1;
            end
        end
`endif
    end

    // NOTE: ready is masked by rst so a client never sees an acceptance that the held-in-reset FSM drops.
    always_comb begin
        req_ready_o = '0;
        if (state == S_IDLE && grant_any && !rst) req_ready_o[grant_idx] = 1'b1;
    end

    assign cur_id   = 4'(ID_BASE) + 4'(lat_g);
    assign lane     = lat_addr[OFF_W-1:0] >> LO_W;
    assign addr_lo  = lat_addr[LO_W-1:0];
    assign wd_sh    = lat_wdata << {addr_lo, 3'b000};
    assign ws_sh    = lat_wstrb << addr_lo;
    assign rd_slice = axi_rdata[int'(lane)*DATA_W +: DATA_W] >> {addr_lo, 3'b000};

    assign axi_arvalid = (state == S_AR);
    assign axi_araddr  = lat_addr;
    assign axi_arid    = cur_id;
    assign axi_arsize  = lat_size;
    assign axi_arlen   = 8'd0;
    assign axi_arburst = 2'b01;
    assign axi_rready  = (state == S_R);
    assign axi_awvalid = (state == S_WR) && !aw_done;
    assign axi_awaddr  = lat_addr;
    assign axi_awid    = cur_id;
    assign axi_awsize  = lat_size;
    assign axi_awlen   = 8'd0;
    assign axi_awburst = 2'b01;
    assign axi_wvalid  = (state == S_WR) && !w_done;
    assign axi_wdata   = {L{wd_sh}};
    assign axi_wstrb   = BB'(ws_sh) << (int'(lane) * DB);
    assign axi_wlast   = 1'b1;
    assign axi_bready  = (state == S_B);

    // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= GW'(NM - 1);
            lat_g       <= '0;
            lat_addr    <= '0;
            lat_size    <= '0;
            lat_wdata   <= '0;
            lat_wstrb   <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        lat_g     <= grant_idx;
                        lat_addr  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
                        lat_size  <= req_size[int'(grant_idx)*3 +: 3];
                        lat_wdata <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
                        lat_wstrb <= req_wstrb[int'(grant_idx)*DB +: DB];
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        state     <= req_write[grant_idx] ? S_WR : S_AR;
                    end
                end
                S_AR: if (axi_arready) state <= S_R;
                S_R: begin
                    if (axi_rvalid && axi_rlast) begin
                        rsp_valid_o <= NM'(1) << lat_g;
                        rsp_rdata_o <= rd_slice;
                        rsp_err_o   <= (axi_rresp != 2'b00) || (axi_rid != cur_id);
                        last_grant  <= lat_g;
                        state       <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (axi_awready) aw_done <= 1'b1;
                    if (axi_wready)  w_done  <= 1'b1;
                    if ((aw_done || axi_awready) && (w_done || axi_wready)) state <= S_B;
                end
                S_B: begin
                    if (axi_bvalid) begin
                        rsp_valid_o <= NM'(1) << lat_g;
                        rsp_err_o   <= (axi_bresp != 2'b00) || (axi_bid != cur_id);
                        last_grant  <= lat_g;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
